// File: rtl/entrada_operandos.sv
// Operand-entry stage for the 4-bit adder: successive button presses capture
// numero1, then numero2, then clear both, counting completed pairs.
module entrada_operandos #(
    parameter int LARGURA      = 4,
    parameter int LARGURA_CONT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LARGURA-1:0]      chaves,
    input  logic                    botao,
    output logic [LARGURA-1:0]      numero1,
    output logic [LARGURA-1:0]      numero2,
    output logic                    pronto,
    output logic [1:0]              estado,
    output logic [LARGURA_CONT-1:0] contador
);

    typedef enum logic [1:0] {
        ESPERA_N1 = 2'd0,
        ESPERA_N2 = 2'd1,
        PRONTO    = 2'd2
    } estado_t;

    estado_t estado_atual;
    logic    botao_ant;
    logic    pulso;

    assign pulso  = botao & ~botao_ant;
    assign estado = estado_atual;

    // botao_ant resets to 1 so a button held through reset release is not a press
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_atual <= ESPERA_N1;
            numero1      <= '0;
            numero2      <= '0;
            pronto       <= 1'b0;
            contador     <= '0;
            botao_ant    <= 1'b1;
        end else begin
            botao_ant <= botao;
            case (estado_atual)
                ESPERA_N1: begin
                    if (pulso) begin
                        numero1      <= chaves;
                        estado_atual <= ESPERA_N2;
                    end
                end
                ESPERA_N2: begin
                    if (pulso) begin
                        numero2      <= chaves;
                        pronto       <= 1'b1;
                        contador     <= contador + 1'b1;
                        estado_atual <= PRONTO;
                    end
                end
                PRONTO: begin
                    if (pulso) begin
                        numero1      <= '0;
                        numero2      <= '0;
                        pronto       <= 1'b0;
                        estado_atual <= ESPERA_N1;
                    end
                end
                // unused encoding falls back to ESPERA_N1, operands kept
                default: begin
                    pronto       <= 1'b0;
                    estado_atual <= ESPERA_N1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entrada_operandos.sv
// Self-checking bench for entrada_operandos: a vector table plus hand-written
// sequences, with expectations queued at drive time and popped after each edge.
module tb_entrada_operandos;

    logic       clock;
    logic       reset;
    logic [3:0] chaves;
    logic       botao;
    logic [3:0] numero1;
    logic [3:0] numero2;
    logic       pronto;
    logic [1:0] estado;
    logic [3:0] contador;

    entrada_operandos #(
        .LARGURA      (4),
        .LARGURA_CONT (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .chaves   (chaves),
        .botao    (botao),
        .numero1  (numero1),
        .numero2  (numero2),
        .pronto   (pronto),
        .estado   (estado),
        .contador (contador)
    );

    typedef struct {
        logic       rst;
        logic       btn;
        logic [3:0] ch;
        logic [3:0] n1;
        logic [3:0] n2;
        logic       pr;
        logic [1:0] est;
        logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0] n1;
        logic [3:0] n2;
        logic       pr;
        logic [1:0] est;
        logic [3:0] cnt;
    } exp_t;

    exp_t fila[$];
    vec_t tabela[15];
    int   comparacoes = 0;
    int   erros       = 0;
    int   passo       = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input string nome, input int atual, input int esperado);
        comparacoes++;
        if (atual != esperado) begin
            erros++;
            $display("[TB] FAIL %s at step %0d: got %0d, expected %0d", nome, passo, atual, esperado);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (fila.size() == 0) begin
            comparacoes++;
            erros++;
            $display("[TB] FAIL scoreboard_empty at step %0d: got 0 entries, expected 1", passo);
            return;
        end
        e = fila.pop_front();
        compare("numero1",  int'(numero1),  int'(e.n1));
        compare("numero2",  int'(numero2),  int'(e.n2));
        compare("pronto",   int'(pronto),   int'(e.pr));
        compare("estado",   int'(estado),   int'(e.est));
        compare("contador", int'(contador), int'(e.cnt));
    endtask

    // Drive one cycle of inputs, queue its expectation, then check after the edge
    task automatic applyStimulus(input logic rst, input logic btn, input logic [3:0] ch,
                                 input logic [3:0] n1, input logic [3:0] n2, input logic pr,
                                 input logic [1:0] est, input logic [3:0] cnt);
        exp_t e;
        reset  = rst;
        botao  = btn;
        chaves = ch;
        e.n1 = n1; e.n2 = n2; e.pr = pr; e.est = est; e.cnt = cnt;
        fila.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
        passo++;
    endtask

    initial begin
        logic [3:0] cnt_esp;
        logic [3:0] k;
        logic [3:0] kn;

        reset  = 1'b1;
        botao  = 1'b1;
        chaves = 4'd0;

        // Reset with button held, release with button still held, then the 9+7 pair
        tabela[0]  = '{1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[1]  = '{1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[2]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[3]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[4]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[5]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[6]  = '{1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[7]  = '{1'b0, 1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0};
        tabela[8]  = '{1'b0, 1'b1, 4'd9, 4'd9, 4'd0, 1'b0, 2'd1, 4'd0};
        tabela[9]  = '{1'b0, 1'b0, 4'd3, 4'd9, 4'd0, 1'b0, 2'd1, 4'd0};
        tabela[10] = '{1'b0, 1'b0, 4'd7, 4'd9, 4'd0, 1'b0, 2'd1, 4'd0};
        tabela[11] = '{1'b0, 1'b1, 4'd7, 4'd9, 4'd7, 1'b1, 2'd2, 4'd1};
        tabela[12] = '{1'b0, 1'b0, 4'd7, 4'd9, 4'd7, 1'b1, 2'd2, 4'd1};
        tabela[13] = '{1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 1'b0, 2'd0, 4'd1};
        tabela[14] = '{1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 2'd0, 4'd1};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tabela[i].rst, tabela[i].btn, tabela[i].ch,
                          tabela[i].n1, tabela[i].n2, tabela[i].pr, tabela[i].est, tabela[i].cnt);
            if (i == 11)
                compare("soma_somador", int'({1'b0, numero1} + {1'b0, numero2}), 16);
        end

        // Long press: 20 cycles high with changing switches captures only once
        applyStimulus(1'b0, 1'b1, 4'd4, 4'd4, 4'd0, 1'b0, 2'd1, 4'd1);
        for (int i = 1; i < 20; i++)
            applyStimulus(1'b0, 1'b1, 4'(i), 4'd4, 4'd0, 1'b0, 2'd1, 4'd1);
        applyStimulus(1'b0, 1'b0, 4'd11, 4'd4, 4'd0, 1'b0, 2'd1, 4'd1);

        // Switches toggling in ESPERA_N2 without a press are ignored
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'd4, 4'd0, 1'b0, 2'd1, 4'd1);
        applyStimulus(1'b0, 1'b1, 4'd2, 4'd4, 4'd2, 1'b1, 2'd2, 4'd2);
        applyStimulus(1'b0, 1'b0, 4'd8, 4'd4, 4'd2, 1'b1, 2'd2, 4'd2);
        applyStimulus(1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 1'b0, 2'd0, 4'd2);
        applyStimulus(1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 1'b0, 2'd0, 4'd2);

        // Counter wrap: reset, then 17 full pairs; count reads 0 after 16, 1 after 17
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0);
        cnt_esp = 4'd0;
        for (int p = 1; p <= 17; p++) begin
            k  = 4'(p);
            kn = ~k;
            applyStimulus(1'b0, 1'b0, k,  4'd0, 4'd0, 1'b0, 2'd0, cnt_esp);
            applyStimulus(1'b0, 1'b1, k,  k,    4'd0, 1'b0, 2'd1, cnt_esp);
            applyStimulus(1'b0, 1'b0, kn, k,    4'd0, 1'b0, 2'd1, cnt_esp);
            cnt_esp = 4'(p % 16);
            applyStimulus(1'b0, 1'b1, kn, k,    kn,   1'b1, 2'd2, cnt_esp);
            applyStimulus(1'b0, 1'b0, kn, k,    kn,   1'b1, 2'd2, cnt_esp);
            applyStimulus(1'b0, 1'b1, kn, 4'd0, 4'd0, 1'b0, 2'd0, cnt_esp);
            if (p == 16)
                compare("contador_wrap16", int'(contador), 0);
            if (p == 17)
                compare("contador_par17", int'(contador), 1);
        end

        // Reset together with a press in ESPERA_N2 discards numero1 and loads nothing
        applyStimulus(1'b0, 1'b0, 4'd15, 4'd0,  4'd0, 1'b0, 2'd0, 4'd1);
        applyStimulus(1'b0, 1'b1, 4'd15, 4'd15, 4'd0, 1'b0, 2'd1, 4'd1);
        applyStimulus(1'b0, 1'b0, 4'd6,  4'd15, 4'd0, 1'b0, 2'd1, 4'd1);
        applyStimulus(1'b1, 1'b1, 4'd6,  4'd0,  4'd0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'd6,  4'd0,  4'd0, 1'b0, 2'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 4'd6,  4'd0,  4'd0, 1'b0, 2'd0, 4'd0);

        if (fila.size() != 0) begin
            comparacoes++;
            erros++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", fila.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparacoes, erros);
        $finish;
    end

endmodule

// File: doc/entrada_operandos.md
# entrada_operandos

Sequential operand-entry stage that sits directly upstream of the 4-bit ripple-carry adder `somador_4bits`. It takes one shared set of switches and a single debounced push-button. Successive presses capture the first operand, then the second, then clear. It drives `numero1`/`numero2` as registered values into the adder, flags when both are valid, and counts completed operand pairs.

## Interface
Parameters:
- `LARGURA`, 4: operand width; must equal the adder's operand width.
- `LARGURA_CONT`, 4: width of the completed-pair counter.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `chaves`  in  LARGURA  switch value sampled as an operand.
- `botao`  in  1  debounced button level, synchronous to `clock`; the block detects its rising edge.
- `numero1`  out  LARGURA  registered first operand, wired to the adder's `numero1`.
- `numero2`  out  LARGURA  registered second operand, wired to the adder's `numero2`.
- `pronto`  out  1  high while both operands are held; the adder result is meaningful.
- `estado`  out  2  current FSM state: 0 = ESPERA_N1, 1 = ESPERA_N2, 2 = PRONTO. Encoding 3 is unused.
- `contador`  out  LARGURA_CONT  number of completed pairs, modulo 2^LARGURA_CONT.

## Operation
- Edge detect: register `botao_ant` <= `botao` every cycle. Define `pulso = botao & ~botao_ant` (combinational). One press yields exactly one `pulso`, however long it is held.
- FSM actions on a rising `clock` edge with `pulso = 1`:
  - ESPERA_N1: `numero1` <= `chaves`; go to ESPERA_N2.
  - ESPERA_N2: `numero2` <= `chaves`; `pronto` <= 1; `contador` <= `contador` + 1; go to PRONTO.
  - PRONTO: `numero1`, `numero2` <= 0; `pronto` <= 0; go to ESPERA_N1.
- When `pulso = 0`: all registers hold their values. `chaves` changes are ignored outside the capture edge.
- Unused encoding 3 recovers to ESPERA_N1 on the next edge, with `pronto` = 0 and operands unchanged.
- `contador` wraps from 2^LARGURA_CONT - 1 to 0 with no flag.
- `pronto` is asserted only in PRONTO. It is a registered output, not decoded from `estado` through logic with glitches.
- Width rule: the downstream adder result is LARGURA+1 bits. This block does no arithmetic on operands.

## Timing
- Reset (synchronous, evaluated at the rising edge): `numero1` = 0, `numero2` = 0, `pronto` = 0, `estado` = ESPERA_N1, `contador` = 0, `botao_ant` = 1.
  - Resetting `botao_ant` to 1 ensures a button held through reset release does not register a press.
- Reset has priority over `pulso` on the same edge.
- Reset mid-operation (any state) discards partially entered operands.
- Latency: `botao` rises before edge N, so `pulso` = 1 at edge N. The captured operand, the new `estado`, and `pronto` are visible after edge N (one cycle).
  - The adder is combinational, so its result is valid in the same cycle `pronto` rises.
- Minimum press spacing: `botao` must be low for at least one sampled edge between presses. Presses on consecutive cycles are impossible by construction.
- `chaves` needs to be stable only at the capture edge.

## Test plan
- Reset → all outputs are zero, `estado` = 0, `pronto` = 0. Hold `botao` = 1 through reset release → no capture; `estado` stays 0 for at least 5 cycles.
- Basic pair entry:
  - `chaves` = 4'd9, press → `numero1` = 9, `estado` = 1.
  - `chaves` = 4'd7, press → `numero2` = 7, `pronto` = 1, `contador` = 1; adder result = 5'd16.
  - Third press → both operands = 0, `pronto` = 0, `estado` = 0.
- Long press: hold `botao` high for 20 cycles in ESPERA_N1 → exactly one capture; `estado` = 1, not 2.
- Switch changes ignored: in ESPERA_N2 with `pronto` = 0, toggle `chaves` with no press → `numero1`/`numero2` are unchanged.
- Counter wrap: complete 16 pairs → `contador` returns to 0; on the 17th pair → `contador` = 1.
- Reset mid-operation: capture `numero1` = 15, then assert `reset` in ESPERA_N2 together with a press → after the edge all outputs are at reset values and `numero2` is not loaded.
